// File: rtl/rsa_cmd_parser.sv
// Purpose : assembles 'E'/'D'/'K' command frames from UART bytes into shadow registers,
//           commits keys or a message to the RSA core and pulses start when the core is idle.
// Latency : start_o and the new msg_o/eORd_o appear one cycle after the last frame byte when idle;
//           from PEND they follow two cycles after finish_i.
// Backpressure: no flow control toward the UART. Bytes arriving in PEND/COMMIT are dropped and flagged on err_o.
// Ports   : clk/reset (sync, active-high); rx_valid_i/rx_data_i byte stream in; finish_i from core;
//           start_o, eORd_o, msg_o, e_o, d_o, n_o to core; busy_o core-busy status; err_o protocol error pulse.
module rsa_cmd_parser #(
    parameter int WIDTH_DEG   = 8,
    parameter int WIDTH_N     = 8,
    parameter int WIDTH_MSG_I = 8,
    parameter int E_RST       = 7,
    parameter int D_RST       = 13,
    parameter int N_RST       = 33,
    parameter int TIMEOUT_CYC = 250_000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   rx_valid_i,
    input  logic [7:0]             rx_data_i,
    input  logic                   finish_i,
    output logic                   start_o,
    output logic                   eORd_o,
    output logic [WIDTH_MSG_I-1:0] msg_o,
    output logic [WIDTH_DEG-1:0]   e_o,
    output logic [WIDTH_DEG-1:0]   d_o,
    output logic [WIDTH_N-1:0]     n_o,
    output logic                   busy_o,
    output logic                   err_o
);

    localparam int B_DEG     = (WIDTH_DEG + 7) / 8;
    localparam int B_N       = (WIDTH_N + 7) / 8;
    localparam int B_MSG     = (WIDTH_MSG_I + 7) / 8;
    localparam int MSG_BITS  = 8 * B_MSG;
    localparam int DEG_BITS  = 8 * B_DEG;
    localparam int N_BITS    = 8 * B_N;
    localparam int KEY_BYTES = 2 * B_DEG + B_N;
    localparam int KEY_BITS  = 8 * KEY_BYTES;
    localparam int MAX_BYTES = (KEY_BYTES > B_MSG) ? KEY_BYTES : B_MSG;
    localparam int CNT_W     = $clog2(MAX_BYTES + 1);
    localparam int TO_W      = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MSG,
        S_KEY,
        S_PEND,
        S_COMMIT
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;      // bytes still expected in the frame
    logic [TO_W-1:0]        idle_q, idle_d;    // idle cycles since the last byte
    logic                   key_q, key_d;      // current frame is a key frame
    logic                   enc_q, enc_d;      // current message frame is encrypt
    logic [MSG_BITS-1:0]    msg_sh_q, msg_sh_d;
    logic [KEY_BITS-1:0]    key_sh_q, key_sh_d;
    logic                   start_q, start_d;
    logic                   err_q, err_d;
    logic                   busy_q, busy_d;
    logic                   eord_q, eord_d;
    logic [WIDTH_MSG_I-1:0] msg_q, msg_d;
    logic [WIDTH_DEG-1:0]   e_q, e_d;
    logic [WIDTH_DEG-1:0]   d_q, d_d;
    logic [WIDTH_N-1:0]     n_q, n_d;
    logic                   commit_go;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idle_d    = '0;
        key_d     = key_q;
        enc_d     = enc_q;
        msg_sh_d  = msg_sh_q;
        key_sh_d  = key_sh_q;
        start_d   = 1'b0;
        err_d     = 1'b0;
        eord_d    = eord_q;
        msg_d     = msg_q;
        e_d       = e_q;
        d_d       = d_q;
        n_d       = n_q;
        commit_go = 1'b0;

        // Set has priority: a finish landing in the start cycle must not clear the new job.
        busy_d = busy_q;
        if (finish_i) begin
            busy_d = 1'b0;
        end
        if (start_q) begin
            busy_d = 1'b1;
        end

        unique case (state_q)
            S_IDLE: begin
                if (rx_valid_i) begin
                    case (rx_data_i)
                        8'h45: begin
                            enc_d   = 1'b1;
                            key_d   = 1'b0;
                            cnt_d   = CNT_W'(B_MSG);
                            state_d = S_MSG;
                        end
                        8'h44: begin
                            enc_d   = 1'b0;
                            key_d   = 1'b0;
                            cnt_d   = CNT_W'(B_MSG);
                            state_d = S_MSG;
                        end
                        8'h4B: begin
                            key_d   = 1'b1;
                            cnt_d   = CNT_W'(KEY_BYTES);
                            state_d = S_KEY;
                        end
                        default: err_d = 1'b1;
                    endcase
                end
            end
            S_MSG, S_KEY: begin
                if (rx_valid_i) begin
                    if (state_q == S_MSG) begin
                        msg_sh_d = (msg_sh_q << 8) | MSG_BITS'(rx_data_i);
                    end else begin
                        key_sh_d = (key_sh_q << 8) | KEY_BITS'(rx_data_i);
                    end
                    if (cnt_q == CNT_W'(1)) begin
                        commit_go = ~busy_q;
                        state_d   = busy_q ? S_PEND : S_COMMIT;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end else if (idle_q == TO_W'(TIMEOUT_CYC)) begin
                    // Silence too long: abandon the frame, shadows are simply overwritten later.
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    idle_d = idle_q + 1'b1;
                end
            end
            S_PEND: begin
                if (rx_valid_i) begin
                    err_d = 1'b1;
                end
                if (!busy_q) begin
                    commit_go = 1'b1;
                    state_d   = S_COMMIT;
                end
            end
            S_COMMIT: begin
                if (rx_valid_i) begin
                    err_d = 1'b1;
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Visible registers load on entry to COMMIT so they are valid while start_o is high.
        // The shadow *_d values already include a last byte arriving this cycle.
        if (commit_go) begin
            if (key_q) begin
                e_d = WIDTH_DEG'(key_sh_d[KEY_BITS-1 -: DEG_BITS]);
                d_d = WIDTH_DEG'(key_sh_d[KEY_BITS-DEG_BITS-1 -: DEG_BITS]);
                n_d = WIDTH_N'(key_sh_d[N_BITS-1:0]);
            end else begin
                msg_d   = WIDTH_MSG_I'(msg_sh_d);
                eord_d  = enc_q;
                start_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            idle_q   <= '0;
            key_q    <= 1'b0;
            enc_q    <= 1'b0;
            msg_sh_q <= '0;
            key_sh_q <= '0;
            start_q  <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            eord_q   <= 1'b0;
            msg_q    <= '0;
            e_q      <= WIDTH_DEG'(E_RST);
            d_q      <= WIDTH_DEG'(D_RST);
            n_q      <= WIDTH_N'(N_RST);
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idle_q   <= idle_d;
            key_q    <= key_d;
            enc_q    <= enc_d;
            msg_sh_q <= msg_sh_d;
            key_sh_q <= key_sh_d;
            start_q  <= start_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
            eord_q   <= eord_d;
            msg_q    <= msg_d;
            e_q      <= e_d;
            d_q      <= d_d;
            n_q      <= n_d;
        end
    end

    assign start_o = start_q;
    assign err_o   = err_q;
    assign busy_o  = busy_q;
    assign eORd_o  = eord_q;
    assign msg_o   = msg_q;
    assign e_o     = e_q;
    assign d_o     = d_q;
    assign n_o     = n_q;

endmodule

// File: tb/tb_rsa_cmd_parser.sv
// Purpose : directed check of rsa_cmd_parser framing, commit timing, busy tracking, errors and reset.
// Latency : inputs driven 1 time unit after a rising edge, outputs checked 1 time unit after an edge.
// Backpressure: none; the bench spaces bytes by at least one idle cycle.
module tb_rsa_cmd_parser;

    localparam int TO = 20;

    logic       clk;
    logic       reset;
    logic       rx_valid_i;
    logic [7:0] rx_data_i;
    logic       finish_i;
    logic       start_o;
    logic       eORd_o;
    logic [7:0] msg_o;
    logic [7:0] e_o;
    logic [7:0] d_o;
    logic [7:0] n_o;
    logic       busy_o;
    logic       err_o;

    int n_cmp = 0;
    int n_bad = 0;
    int start_cnt = 0;
    int err_cnt = 0;
    int err_base;
    int start_base;

    rsa_cmd_parser #(
        .WIDTH_DEG  (8),
        .WIDTH_N    (8),
        .WIDTH_MSG_I(8),
        .E_RST      (7),
        .D_RST      (13),
        .N_RST      (33),
        .TIMEOUT_CYC(TO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_valid_i(rx_valid_i),
        .rx_data_i (rx_data_i),
        .finish_i  (finish_i),
        .start_o   (start_o),
        .eORd_o    (eORd_o),
        .msg_o     (msg_o),
        .e_o       (e_o),
        .d_o       (d_o),
        .n_o       (n_o),
        .busy_o    (busy_o),
        .err_o     (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters sampled on the falling edge, away from register updates.
    always @(negedge clk) begin
        if (start_o) start_cnt++;
        if (err_o) err_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Returns 1 time unit after the edge that sampled the byte.
    task automatic send_byte(input logic [7:0] b);
        @(posedge clk);
        #1;
        rx_valid_i = 1'b1;
        rx_data_i  = b;
        @(posedge clk);
        #1;
        rx_valid_i = 1'b0;
        rx_data_i  = 8'h00;
    endtask

    task automatic pulse_finish();
        @(posedge clk);
        #1;
        finish_i = 1'b1;
        @(posedge clk);
        #1;
        finish_i = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        step(2);
        reset = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        rx_valid_i = 1'b0;
        rx_data_i  = 8'h00;
        finish_i   = 1'b0;
        step(3);
        reset = 1'b0;

        // Reset state
        check_eq("rst_busy",  32'(busy_o),  'h0);
        check_eq("rst_start", 32'(start_o), 'h0);
        check_eq("rst_err",   32'(err_o),   'h0);
        check_eq("rst_e",     32'(e_o),     'd7);
        check_eq("rst_d",     32'(d_o),     'd13);
        check_eq("rst_n",     32'(n_o),     'd33);
        check_eq("rst_msg",   32'(msg_o),   'h0);
        check_eq("rst_eord",  32'(eORd_o),  'h0);

        // Encrypt frame: start one cycle after the last byte
        send_byte(8'h45);
        check_eq("e1_nostart_cmd", 32'(start_o), 'h0);
        send_byte(8'h02);
        check_eq("e1_start", 32'(start_o), 'h1);
        check_eq("e1_msg",   32'(msg_o),   'h02);
        check_eq("e1_eord",  32'(eORd_o),  'h1);
        check_eq("e1_busy_pre", 32'(busy_o), 'h0);
        step(1);
        check_eq("e1_start_width", 32'(start_o), 'h0);
        check_eq("e1_busy", 32'(busy_o), 'h1);
        step(3);
        check_eq("e1_busy_hold", 32'(busy_o), 'h1);
        pulse_finish();
        check_eq("e1_busy_clr", 32'(busy_o), 'h0);
        check_eq("e1_start_cnt", start_cnt, 1);

        // Key frame: keys update, no start
        send_byte(8'h4B);
        send_byte(8'h03);
        send_byte(8'h07);
        send_byte(8'h21);
        check_eq("k1_e", 32'(e_o), 'h03);
        check_eq("k1_d", 32'(d_o), 'h07);
        check_eq("k1_n", 32'(n_o), 'h21);
        step(3);
        check_eq("k1_no_start", start_cnt, 1);
        check_eq("k1_msg_kept", 32'(msg_o), 'h02);

        // finish while idle is ignored
        pulse_finish();
        check_eq("fin_idle_busy", 32'(busy_o), 'h0);

        // Bad command byte
        send_byte(8'h55);
        check_eq("bad_err", 32'(err_o), 'h1);
        step(1);
        check_eq("bad_err_width", 32'(err_o), 'h0);
        check_eq("bad_err_cnt", err_cnt, 1);
        check_eq("bad_msg_kept",  32'(msg_o),  'h02);
        check_eq("bad_eord_kept", 32'(eORd_o), 'h1);

        // Decrypt frame; finish coincides with start -> busy still set
        send_byte(8'h44);
        send_byte(8'h10);
        check_eq("d1_start", 32'(start_o), 'h1);
        check_eq("d1_msg",   32'(msg_o),   'h10);
        check_eq("d1_eord",  32'(eORd_o),  'h0);
        finish_i = 1'b1;
        step(1);
        finish_i = 1'b0;
        check_eq("d1_set_wins", 32'(busy_o), 'h1);
        pulse_finish();
        check_eq("d1_busy_clr", 32'(busy_o), 'h0);

        // Key frame with TO-1 idle cycles between bytes is still accepted
        err_base = err_cnt;
        send_byte(8'h4B);
        send_byte(8'h09);
        step(TO - 2);
        send_byte(8'h0B);
        send_byte(8'h25);
        check_eq("k2_e", 32'(e_o), 'h09);
        check_eq("k2_d", 32'(d_o), 'h0B);
        check_eq("k2_n", 32'(n_o), 'h25);
        check_eq("k2_no_err", err_cnt, err_base);

        // Timeout mid key frame: one error, keys unchanged
        send_byte(8'h4B);
        send_byte(8'h03);
        step(TO + 10);
        check_eq("to_err_cnt", err_cnt, err_base + 1);
        check_eq("to_e", 32'(e_o), 'h09);
        check_eq("to_d", 32'(d_o), 'h0B);
        check_eq("to_n", 32'(n_o), 'h25);
        send_byte(8'h45);
        send_byte(8'h33);
        check_eq("to_e_start", 32'(start_o), 'h1);
        check_eq("to_e_msg",   32'(msg_o),   'h33);
        check_eq("to_e_eord",  32'(eORd_o),  'h1);
        step(1);
        pulse_finish();

        // Back-to-back frame while busy goes to PEND
        send_byte(8'h45);
        send_byte(8'h05);
        check_eq("p_start1", 32'(start_o), 'h1);
        check_eq("p_msg1",   32'(msg_o),   'h05);
        start_base = start_cnt + 1;
        send_byte(8'h44);
        send_byte(8'h06);
        check_eq("p_no_start", 32'(start_o), 'h0);
        step(3);
        check_eq("p_start_cnt", start_cnt, start_base);
        check_eq("p_msg_held",  32'(msg_o),  'h05);
        check_eq("p_eord_held", 32'(eORd_o), 'h1);
        send_byte(8'h77);
        check_eq("p_overrun_err", 32'(err_o), 'h1);
        pulse_finish();
        check_eq("p_busy_clr", 32'(busy_o), 'h0);
        check_eq("p_start_t1", 32'(start_o), 'h0);
        step(1);
        check_eq("p_start_t2", 32'(start_o), 'h1);
        check_eq("p_msg2",     32'(msg_o),   'h06);
        check_eq("p_eord2",    32'(eORd_o),  'h0);
        step(1);
        check_eq("p_busy2", 32'(busy_o), 'h1);
        pulse_finish();

        // Reset mid-frame
        start_base = start_cnt;
        send_byte(8'h45);
        do_reset();
        step(3);
        check_eq("r_no_start", start_cnt, start_base);
        check_eq("r_busy", 32'(busy_o), 'h0);
        check_eq("r_e",    32'(e_o),    'd7);
        check_eq("r_d",    32'(d_o),    'd13);
        check_eq("r_n",    32'(n_o),    'd33);
        check_eq("r_msg",  32'(msg_o),  'h0);
        send_byte(8'h06);
        check_eq("r_err",   32'(err_o),   'h1);
        check_eq("r_start", 32'(start_o), 'h0);
        step(3);

        check_eq("total_start", start_cnt, 5);
        check_eq("total_err",   err_cnt,   4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
